// File: rtl/ad_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ad_capture_ctrl
//  Description : AD9280 capture sequencer. Generates a divided ADC clock,
//                strobes one conversion per ADC clock period, and runs a
//                start/trigger/capture/done sequence that writes samples
//                into a waveform buffer through a registered RAM write port.
//  Revision    : 1.0 - initial release
// ============================================================================
module ad_capture_ctrl #(
  parameter int          CLK_DIV    = 1,
  parameter int          SAMPLE_NUM = 256,
  parameter logic [7:0]  TRIG_LEVEL = 8'd128,
  parameter int          ADDR_W     = $clog2(SAMPLE_NUM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        ad_data,
  input  logic              ad_otr,
  input  logic              start,
  input  logic              trig_en,
  input  logic              abort,
  output logic              ad_clk,
  output logic              busy,
  output logic              done,
  output logic              otr_flag,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  localparam int                  c_div_w     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_div_w-1:0]  c_div_last  = c_div_w'(CLK_DIV - 1);
  localparam logic [ADDR_W-1:0]   c_last_addr = ADDR_W'(SAMPLE_NUM - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_CAPT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_div_w-1:0]  r_div_cnt;
  logic                r_ad_clk;
  logic [ADDR_W-1:0]   r_smp_cnt;
  logic [ADDR_W-1:0]   w_smp_cnt_nxt;
  logic [7:0]          r_prev_smp;
  logic                r_prev_vld;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [7:0]          r_wr_data;
  logic                r_done;
  logic                r_otr_flag;
  logic                w_otr_nxt;
  logic                w_stb;
  logic                w_trig;
  logic                w_wr;
  logic                w_done_nxt;
  logic                w_prev_vld_clr;

  // Sample strobe sits on the edge that drives ad_clk low, so the ADC data
  // has had a full high phase to settle.
  assign w_stb  = (r_div_cnt == c_div_last) && r_ad_clk;
  assign w_trig = w_stb && r_prev_vld && (r_prev_smp < TRIG_LEVEL) && (ad_data >= TRIG_LEVEL);

  // Free-running divider and ADC clock toggle; only reset stops it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_ad_clk  <= 1'b0;
    end else if (r_div_cnt == c_div_last) begin
      r_div_cnt <= '0;
      r_ad_clk  <= ~r_ad_clk;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // Next-state, write decision and flag updates; abort overrides everything.
  always_comb begin
    w_state_nxt    = r_state;
    w_wr           = 1'b0;
    w_smp_cnt_nxt  = r_smp_cnt;
    w_otr_nxt      = r_otr_flag;
    w_prev_vld_clr = 1'b0;
    w_done_nxt     = 1'b0;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_otr_nxt      = 1'b0;
            w_smp_cnt_nxt  = '0;
            w_prev_vld_clr = 1'b1;
            w_state_nxt    = trig_en ? ST_ARM : ST_CAPT;
          end
        end
        ST_ARM: begin
          // The triggering sample itself becomes address 0.
          if (w_trig) begin
            w_wr          = 1'b1;
            w_smp_cnt_nxt = r_smp_cnt + 1'b1;
            if (ad_otr) w_otr_nxt = 1'b1;
            w_state_nxt   = ST_CAPT;
          end
        end
        ST_CAPT: begin
          if (w_stb) begin
            w_wr          = 1'b1;
            w_smp_cnt_nxt = r_smp_cnt + 1'b1;
            if (ad_otr) w_otr_nxt = 1'b1;
            if (r_smp_cnt == c_last_addr) begin
              w_state_nxt = ST_DONE;
              w_done_nxt  = 1'b1;
            end
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State, sample counter and sticky out-of-range flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_smp_cnt  <= '0;
      r_otr_flag <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_smp_cnt  <= w_smp_cnt_nxt;
      r_otr_flag <= w_otr_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Previous-sample history for edge triggering; a start discards history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev_smp <= 8'd0;
      r_prev_vld <= 1'b0;
    end else begin
      if (w_stb) r_prev_smp <= ad_data;
      if (w_prev_vld_clr) r_prev_vld <= 1'b0;
      else if (w_stb)     r_prev_vld <= 1'b1;
    end
  end

  // Registered buffer write port; address and data hold between writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= 8'd0;
    end else begin
      r_wr_en <= w_wr;
      if (w_wr) begin
        r_wr_addr <= r_smp_cnt;
        r_wr_data <= ad_data;
      end
    end
  end

  assign ad_clk   = r_ad_clk;
  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;
  assign otr_flag = r_otr_flag;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;

endmodule
`default_nettype wire
